// File: rtl/md6_job_sequencer_pkg.sv
// Shared constants and state type for the MD6 job sequencer.
// Encodings double as debug LED codes.
package md6_job_sequencer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HASH  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_TX    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int CNT_W    = 24;
  localparam int TX_GUARD = 16;
  localparam int TXC_W    = 5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    HASH  = S_HASH,
    READY = S_READY,
    TX    = S_TX,
    DONE  = S_DONE,
    ERR   = S_ERR
  } state_t;

endpackage

// File: rtl/md6_job_sequencer.sv
// Job sequencer between the receiver, the MD6 mode core and the
// transmitter: hash, hold digest, transmit, release receiver.
module md6_job_sequencer
  import md6_job_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit AUTO_TX        = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic       core_done,
  input  logic       tx_req,
  input  logic       tx_busy,
  output logic       core_enable,
  output logic       tx_start,
  output logic       rx_clear,
  output logic       hash_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] job_count,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TXC_W-1:0] GUARD_LAST =
    TXC_W'(TX_GUARD - 1);

  state_t st;
  state_t nxt;

  logic [CNT_W-1:0] hcnt;
  logic [TXC_W-1:0] tcnt;
  logic             seen;
  logic             pend;
  logic             armed;
  logic             tx_fin;
  logic             clr;

  // Leave TX after the transmitter has run, or after the guard
  // window if it never reported busy.
  assign tx_fin = !tx_busy &&
    (seen ? (tcnt != '0) : (tcnt == GUARD_LAST));

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  if (rx_done && armed) nxt = HASH;
      HASH:  begin
        if (core_done)           nxt = READY;
        else if (hcnt == TMO_LAST) nxt = ERR;
      end
      READY: if (pend && !tx_busy) nxt = TX;
      TX:    if (tx_fin) nxt = DONE;
      DONE:  nxt = IDLE;
      ERR:   if (tx_req) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign clr = ((st == TX) && (nxt == DONE)) ||
               ((st == ERR) && (nxt == IDLE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      hcnt        <= '0;
      tcnt        <= '0;
      seen        <= 1'b0;
      pend        <= 1'b0;
      armed       <= 1'b1;
      core_enable <= 1'b0;
      tx_start    <= 1'b0;
      rx_clear    <= 1'b0;
      hash_valid  <= 1'b0;
      timeout_err <= 1'b0;
      job_count   <= '0;
    end else begin
      st <= nxt;

      if (st == HASH) hcnt <= hcnt + 1'b1;
      else            hcnt <= '0;

      if (st == TX) begin
        if (tcnt != '1) tcnt <= tcnt + 1'b1;
        if (tx_busy)    seen <= 1'b1;
      end else begin
        tcnt <= '0;
        seen <= 1'b0;
      end

      if (st != READY)          pend <= 1'b0;
      else if (nxt == TX)       pend <= 1'b0;
      else if (tx_req || AUTO_TX) pend <= 1'b1;

      // A new job needs rx_done to drop after each release.
      if (clr)           armed <= 1'b0;
      else if (!rx_done) armed <= 1'b1;

      rx_clear    <= clr;
      tx_start    <= (st == READY) && (nxt == TX);
      core_enable <= nxt inside {HASH, READY, TX};
      hash_valid  <= nxt inside {READY, TX, DONE};

      if (nxt == ERR) timeout_err <= 1'b1;
      if (st == DONE) job_count <= job_count + 1'b1;
    end
  end

  assign busy  = (st != IDLE);
  assign state = st;

endmodule

// File: doc/md6_job_sequencer.md
MD6_JOB_SEQUENCER -- requirements
Module: md6_job_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: maximum cycles allowed in HASH before a timeout.
REQ-002 Parameter AUTO_TX, default 0: 1 = transmit the digest without waiting for a button request.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_done  in  1  level; receiver holds a complete job (message, d, K, L, r, padding).
REQ-006 core_done  in  1  level; MD6 mode core digest D valid; low while core enable is low.
REQ-007 tx_req  in  1  one-cycle debounced transmit-request pulse.
REQ-008 tx_busy  in  1  level; transmitter is shifting a digest out.
REQ-009 core_enable  out  1  level enable to the MD6 mode core.
REQ-010 tx_start  out  1  one-cycle pulse that starts digest transmission.
REQ-011 rx_clear  out  1  one-cycle pulse that releases the receiver for the next job.
REQ-012 hash_valid  out  1  digest available and not yet consumed.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 timeout_err  out  1  sticky timeout flag.
REQ-015 job_count  out  8  count of completed jobs.
REQ-016 state  out  3  encoded current state, for debug LEDs.

Function
REQ-017 States and encodings SHALL be IDLE=0, HASH=1, READY=2, TX=3, DONE=4, ERR=5.
REQ-018 IDLE: rx_done=1 SHALL go to HASH on the next edge and clear the 24-bit cycle counter.
REQ-019 core_enable SHALL be 1 exactly in HASH, READY and TX; it is registered, with no combinational path from inputs.
REQ-020 HASH: the counter SHALL increment each cycle.
REQ-021 HASH exit on core_done=1 SHALL go to READY.
REQ-022 HASH exit on counter = TIMEOUT_CYCLES-1 with core_done=0 SHALL go to ERR.
REQ-023 If core_done and timeout occur in the same cycle, core_done SHALL win.
REQ-024 READY: hash_valid SHALL be 1.
REQ-025 A tx_req pulse in READY (or any READY cycle when AUTO_TX=1) SHALL set a pending flag.
REQ-026 With the pending flag set and tx_busy=0, the block SHALL pulse tx_start for one cycle, clear the pending flag and go to TX.
REQ-027 tx_req pulses in any state other than READY and ERR SHALL be ignored.
REQ-028 TX: hash_valid SHALL stay 1.
REQ-029 TX SHALL be left for DONE only after at least 2 cycles in TX, once tx_busy has been seen high and is now 0.
REQ-030 If tx_busy is never seen high within 16 cycles of tx_start, TX SHALL go to DONE anyway.
REQ-031 DONE (one cycle): rx_clear SHALL be 1 and job_count SHALL increment, wrapping 255->0.
REQ-032 From DONE the next state SHALL be IDLE, and hash_valid SHALL drop in that IDLE cycle.
REQ-033 ERR: timeout_err SHALL be set and core_enable SHALL be 0.
REQ-034 A tx_req pulse in ERR SHALL pulse rx_clear and go to IDLE; job_count SHALL NOT change.
REQ-035 timeout_err SHALL remain set until reset.
REQ-036 The first job accepted after ERR SHALL behave exactly as after reset, apart from the timeout_err flag.
REQ-037 rx_done still high on the IDLE cycle after DONE SHALL NOT start a new job; a new job needs rx_done seen low for at least 1 cycle after rx_clear.

Reset
REQ-038 On reset=1, asynchronously: state=IDLE, counters=0, pending=0, and every output=0 (state output 3'd0).
REQ-039 Reset mid-HASH or mid-TX SHALL drop core_enable immediately, with no rx_clear or tx_start pulse.

Structure
REQ-040 State encodings, counter width (24) and the TX guard limit (16) SHALL be localparams in the shared parameters header.
REQ-041 No sub-module; the block is a single FSM plus counters, instantiated in the top level between the receiver, the MD6 mode core and the transmitter.

Verification
REQ-042 Normal job: rx_done=1, core_done 50 cycles later, tx_req, tx_busy high for 100 cycles -> one tx_start, one rx_clear, job_count=1, back in IDLE.
REQ-043 Timeout: TIMEOUT_CYCLES=64, core_done never rises -> ERR at cycle 64, timeout_err=1, core_enable=0; tx_req -> rx_clear, IDLE, job_count unchanged.
REQ-044 Collision: core_done rises on cycle TIMEOUT_CYCLES-1 -> READY, timeout_err stays 0.
REQ-045 AUTO_TX=1 with tx_busy held high 10 cycles in READY -> tx_start exactly once, only after tx_busy falls.
REQ-046 Wrap and re-arm: 256 jobs -> job_count=0; rx_done left high after DONE -> no second HASH until it toggles low.
REQ-047 Reset asserted mid-HASH -> all outputs 0 asynchronously, no rx_clear pulse.
